// File: rtl/vita_sync_pkg.sv
// Shared types, sync-word constants and default widths for the VITA2000 frame sequencer.
// Included by vita_lock_monitor and vita_frame_sequencer.
package vita_sync_pkg;

   localparam int TP_LOCK_COUNT_DEF = 16;
   localparam int INV_LIMIT_DEF     = 4;
   localparam int WORD_W_DEF        = 11;
   localparam int LINE_W_DEF        = 12;

   localparam logic [7:0] SYNC_FS  = 8'hAA;
   localparam logic [7:0] SYNC_FE  = 8'hCA;
   localparam logic [7:0] SYNC_LS  = 8'h2A;
   localparam logic [7:0] SYNC_LE  = 8'h4A;
   localparam logic [7:0] SYNC_BL  = 8'h05;
   localparam logic [7:0] SYNC_IMG = 8'h0D;
   localparam logic [7:0] SYNC_CRC = 8'h16;
   localparam logic [7:0] SYNC_TP  = 8'hE9;

   typedef enum logic [1:0] {
      UNLOCKED,
      IDLE,
      LINE,
      GAP
   } seq_state_t;

   typedef enum logic [3:0] {
      CODE_NONE,
      CODE_INV,
      CODE_TP,
      CODE_FS,
      CODE_FE,
      CODE_LS,
      CODE_LE,
      CODE_IMG,
      CODE_CRC,
      CODE_BL
   } sync_code_t;

   // Collapses the decoded flags into one code; a non-one-hot input keeps the highest-priority flag.
   function automatic sync_code_t resolve_code(
      input logic fs, input logic fe, input logic ls, input logic le, input logic bl,
      input logic tp, input logic img, input logic crc, input logic inv
   );
      if (inv)      return CODE_INV;
      else if (tp)  return CODE_TP;
      else if (fs)  return CODE_FS;
      else if (fe)  return CODE_FE;
      else if (ls)  return CODE_LS;
      else if (le)  return CODE_LE;
      else if (img) return CODE_IMG;
      else if (crc) return CODE_CRC;
      else if (bl)  return CODE_BL;
      else          return CODE_NONE;
   endfunction

endpackage

// File: rtl/vita_lock_monitor.sv
// Link lock tracker: declares lock after a run of training patterns and drops it
// after a run of invalid codes, pulsing realign_req on the drop.
module vita_lock_monitor
   import vita_sync_pkg::*;
#(
   parameter int TP_LOCK_COUNT = TP_LOCK_COUNT_DEF,
   parameter int INV_LIMIT     = INV_LIMIT_DEF
)
(
   input  logic       par_clock,
   input  logic       reset_n,
   input  logic       enable,
   input  sync_code_t code,
   output logic       locked,
   output logic       realign_req,
   output logic       lock_gain,
   output logic       lock_loss
);

   localparam int TP_W  = $clog2(TP_LOCK_COUNT + 1);
   localparam int INV_W = $clog2(INV_LIMIT + 1);

   logic [TP_W-1:0]  tp_cnt;
   logic [INV_W-1:0] inv_cnt;

   // Same-cycle lock events so the sequencer FSM changes state on the same edge as locked.
   always_comb begin
      lock_gain = enable && !locked && (code == CODE_TP)
                  && (tp_cnt == TP_W'(TP_LOCK_COUNT - 1));
      lock_loss = enable && locked && (code == CODE_INV)
                  && (inv_cnt == INV_W'(INV_LIMIT - 1));
   end

   always_ff @(posedge par_clock or negedge reset_n) begin
      if (!reset_n) begin
         locked      <= 1'b0;
         realign_req <= 1'b0;
         tp_cnt      <= '0;
         inv_cnt     <= '0;
      end else if (!enable) begin
         locked      <= 1'b0;
         realign_req <= 1'b0;
         tp_cnt      <= '0;
         inv_cnt     <= '0;
      end else begin
         realign_req <= 1'b0;
         if (!locked) begin
            inv_cnt <= '0;
            if (lock_gain) begin
               locked <= 1'b1;
               tp_cnt <= '0;
            end else if (code == CODE_TP) begin
               tp_cnt <= tp_cnt + TP_W'(1);
            end else begin
               tp_cnt <= '0;
            end
         end else begin
            tp_cnt <= '0;
            if (lock_loss) begin
               locked      <= 1'b0;
               realign_req <= 1'b1;
               inv_cnt     <= '0;
            end else if (code == CODE_INV) begin
               inv_cnt <= inv_cnt + INV_W'(1);
            end else begin
               inv_cnt <= '0;
            end
         end
      end
   end

endmodule

// File: rtl/vita_frame_sequencer.sv
// Frame/line sequencer behind the VITA2000 LVDS synchronizer; all outputs registered.
// Optional macro VITA_CRC_CAPTURE_EN adds crc_word/crc_valid capture of the CRC after LE/FE.
module vita_frame_sequencer
   import vita_sync_pkg::*;
#(
   parameter int TP_LOCK_COUNT = TP_LOCK_COUNT_DEF,
   parameter int INV_LIMIT     = INV_LIMIT_DEF,
   parameter int WORD_W        = WORD_W_DEF,
   parameter int LINE_W        = LINE_W_DEF
)
(
   input  logic              par_clock,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              FS,
   input  logic              FE,
   input  logic              LS,
   input  logic              LE,
   input  logic              BL,
   input  logic              TP,
   input  logic              IMG,
   input  logic              CRC,
   input  logic              INV,
   input  logic [31:0]       cam_d,
   input  logic [WORD_W-1:0] cfg_words_per_line,
   output logic              locked,
   output logic              realign_req,
   output logic              pix_valid,
   output logic [31:0]       pix_data,
   output logic              pix_sof,
   output logic              pix_sol,
   output logic              pix_eol,
   output logic              pix_eof,
   output logic [LINE_W-1:0] line_cnt,
   output logic              frame_done,
   output logic              err_seq,
`ifdef VITA_CRC_CAPTURE_EN
   output logic [31:0]       crc_word,
   output logic              crc_valid,
`endif
   output logic              err_len
);

   sync_code_t        code;
   seq_state_t        state;
   logic [WORD_W-1:0] word_cnt;
   logic [WORD_W-1:0] word_cnt_inc;
   logic [LINE_W-1:0] line_cnt_inc;
   logic              len_bad;
   logic              frame_err;
   logic              lock_gain;
   logic              lock_loss;

   // The extra bit keeps a saturated counter from ever matching the configured length.
   always_comb begin
      code         = resolve_code(FS, FE, LS, LE, BL, TP, IMG, CRC, INV);
      word_cnt_inc = (word_cnt == '1) ? word_cnt : word_cnt + WORD_W'(1);
      line_cnt_inc = (line_cnt == '1) ? line_cnt : line_cnt + LINE_W'(1);
      len_bad      = ({1'b0, word_cnt} + (WORD_W + 1)'(1)) != {1'b0, cfg_words_per_line};
   end

   vita_lock_monitor #(
      .TP_LOCK_COUNT (TP_LOCK_COUNT),
      .INV_LIMIT     (INV_LIMIT)
   ) u_lock (
      .par_clock   (par_clock),
      .reset_n     (reset_n),
      .enable      (enable),
      .code        (code),
      .locked      (locked),
      .realign_req (realign_req),
      .lock_gain   (lock_gain),
      .lock_loss   (lock_loss)
   );

   always_ff @(posedge par_clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= UNLOCKED;
         word_cnt   <= '0;
         line_cnt   <= '0;
         frame_err  <= 1'b0;
         pix_data   <= '0;
         pix_valid  <= 1'b0;
         pix_sof    <= 1'b0;
         pix_sol    <= 1'b0;
         pix_eol    <= 1'b0;
         pix_eof    <= 1'b0;
         frame_done <= 1'b0;
         err_seq    <= 1'b0;
         err_len    <= 1'b0;
      end else begin
         pix_data   <= cam_d;
         pix_valid  <= 1'b0;
         pix_sof    <= 1'b0;
         pix_sol    <= 1'b0;
         pix_eol    <= 1'b0;
         pix_eof    <= 1'b0;
         frame_done <= 1'b0;
         err_seq    <= 1'b0;
         err_len    <= 1'b0;
         if (!enable || lock_loss) begin
            state     <= UNLOCKED;
            word_cnt  <= '0;
            line_cnt  <= '0;
            frame_err <= 1'b0;
         end else begin
            case (state)
               UNLOCKED: begin
                  if (lock_gain) state <= IDLE;
               end
               IDLE: begin
                  case (code)
                     CODE_FS: begin
                        state     <= LINE;
                        pix_valid <= 1'b1;
                        pix_sof   <= 1'b1;
                        pix_sol   <= 1'b1;
                        line_cnt  <= '0;
                        word_cnt  <= WORD_W'(1);
                        frame_err <= 1'b0;
                     end
                     CODE_FE, CODE_LS, CODE_LE, CODE_IMG: err_seq <= 1'b1;
                     default: ;
                  endcase
               end
               LINE: begin
                  case (code)
                     CODE_IMG: begin
                        pix_valid <= 1'b1;
                        word_cnt  <= word_cnt_inc;
                     end
                     CODE_LE: begin
                        state     <= GAP;
                        pix_valid <= 1'b1;
                        pix_eol   <= 1'b1;
                        err_len   <= len_bad;
                        frame_err <= frame_err | len_bad;
                     end
                     CODE_FE: begin
                        state      <= IDLE;
                        pix_valid  <= 1'b1;
                        pix_eol    <= 1'b1;
                        pix_eof    <= 1'b1;
                        err_len    <= len_bad;
                        frame_done <= !(frame_err || len_bad);
                     end
                     CODE_BL, CODE_TP, CODE_FS, CODE_LS: begin
                        state   <= IDLE;
                        err_seq <= 1'b1;
                     end
                     default: ;
                  endcase
               end
               GAP: begin
                  case (code)
                     CODE_LS: begin
                        state     <= LINE;
                        pix_valid <= 1'b1;
                        pix_sol   <= 1'b1;
                        line_cnt  <= line_cnt_inc;
                        word_cnt  <= WORD_W'(1);
                     end
                     CODE_FS, CODE_IMG, CODE_LE, CODE_FE: begin
                        state   <= IDLE;
                        err_seq <= 1'b1;
                     end
                     default: ;
                  endcase
               end
               default: state <= UNLOCKED;
            endcase
         end
      end
   end

`ifdef VITA_CRC_CAPTURE_EN
   logic crc_armed;

   // Arms on an accepted LE/FE and captures only the first CRC word that follows it.
   always_ff @(posedge par_clock or negedge reset_n) begin
      if (!reset_n) begin
         crc_armed <= 1'b0;
         crc_word  <= '0;
         crc_valid <= 1'b0;
      end else begin
         crc_valid <= 1'b0;
         if (!enable || lock_loss || state == UNLOCKED) begin
            crc_armed <= 1'b0;
         end else if (crc_armed && code == CODE_CRC) begin
            crc_word  <= cam_d;
            crc_valid <= 1'b1;
            crc_armed <= 1'b0;
         end else if (state == LINE && (code == CODE_LE || code == CODE_FE)) begin
            crc_armed <= 1'b1;
         end else if (code == CODE_FS || code == CODE_LS) begin
            crc_armed <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_vita_frame_sequencer.sv
// Table-driven bench for vita_frame_sequencer with hand-computed expectations.
// Also exercises the VITA_CRC_CAPTURE_EN ports when that macro is defined.
module tb_vita_frame_sequencer;

   localparam logic [8:0] K_NONE = 9'b0_0000_0000;
   localparam logic [8:0] K_FS   = 9'b1_0000_0000;
   localparam logic [8:0] K_FE   = 9'b0_1000_0000;
   localparam logic [8:0] K_LS   = 9'b0_0100_0000;
   localparam logic [8:0] K_LE   = 9'b0_0010_0000;
   localparam logic [8:0] K_BL   = 9'b0_0001_0000;
   localparam logic [8:0] K_TP   = 9'b0_0000_1000;
   localparam logic [8:0] K_IMG  = 9'b0_0000_0100;
   localparam logic [8:0] K_CRC  = 9'b0_0000_0010;
   localparam logic [8:0] K_INV  = 9'b0_0000_0001;

   localparam logic [9:0] F_LOCK = 10'b10_0000_0000;
   localparam logic [9:0] F_REAL = 10'b01_0000_0000;
   localparam logic [9:0] F_VAL  = 10'b00_1000_0000;
   localparam logic [9:0] F_SOF  = 10'b00_0100_0000;
   localparam logic [9:0] F_SOL  = 10'b00_0010_0000;
   localparam logic [9:0] F_EOL  = 10'b00_0001_0000;
   localparam logic [9:0] F_EOF  = 10'b00_0000_1000;
   localparam logic [9:0] F_FD   = 10'b00_0000_0100;
   localparam logic [9:0] F_SEQ  = 10'b00_0000_0010;
   localparam logic [9:0] F_LEN  = 10'b00_0000_0001;

   typedef struct {
      logic        en;
      logic [8:0]  code;
      logic [31:0] data;
      logic [9:0]  flags;
      logic [11:0] line;
   } vec_t;

   logic        parClock;
   logic        resetN;
   logic        enable;
   logic        fs, fe, ls, le, bl, tp, img, crc, inv;
   logic [31:0] camD;
   logic [10:0] cfgWords;
   logic        locked, realignReq, pixValid, pixSof, pixSol, pixEol, pixEof;
   logic        frameDone, errSeq, errLen;
   logic [31:0] pixData;
   logic [11:0] lineCnt;
`ifdef VITA_CRC_CAPTURE_EN
   logic [31:0] crcWord;
   logic        crcValid;
`endif

   int   passCount  = 0;
   int   checkCount = 0;
   vec_t vecs[$];

   vita_frame_sequencer dut (
      .par_clock          (parClock),
      .reset_n            (resetN),
      .enable             (enable),
      .FS                 (fs),
      .FE                 (fe),
      .LS                 (ls),
      .LE                 (le),
      .BL                 (bl),
      .TP                 (tp),
      .IMG                (img),
      .CRC                (crc),
      .INV                (inv),
      .cam_d              (camD),
      .cfg_words_per_line (cfgWords),
      .locked             (locked),
      .realign_req        (realignReq),
      .pix_valid          (pixValid),
      .pix_data           (pixData),
      .pix_sof            (pixSof),
      .pix_sol            (pixSol),
      .pix_eol            (pixEol),
      .pix_eof            (pixEof),
      .line_cnt           (lineCnt),
      .frame_done         (frameDone),
      .err_seq            (errSeq),
`ifdef VITA_CRC_CAPTURE_EN
      .crc_word           (crcWord),
      .crc_valid          (crcValid),
`endif
      .err_len            (errLen)
   );

   initial parClock = 1'b0;
   always #5 parClock = ~parClock;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [9:0] actualFlags();
      return {locked, realignReq, pixValid, pixSof, pixSol, pixEol, pixEof,
              frameDone, errSeq, errLen};
   endfunction

   task automatic addVec(input logic en, input logic [8:0] code,
                         input logic [9:0] flags, input logic [11:0] line);
      vec_t v;
      v.en    = en;
      v.code  = code;
      v.data  = 32'hA500_0000 + 32'(vecs.size());
      v.flags = flags;
      v.line  = line;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input logic en, input logic [8:0] code, input logic [31:0] data);
      @(negedge parClock);
      enable = en;
      {fs, fe, ls, le, bl, tp, img, crc, inv} = code;
      camD = data;
      @(posedge parClock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [53:0] act, input logic [53:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got flags/line/data %h, expected %h", name, act, exp);
   endtask

   initial begin
      resetN   = 1'b0;
      enable   = 1'b0;
      {fs, fe, ls, le, bl, tp, img, crc, inv} = K_NONE;
      camD     = 32'h0;
      cfgWords = 11'd4;
      #1;
      checkOutput("reset", {actualFlags(), lineCnt, pixData}, 54'h0);

      // Lock acquisition: an interrupted run of 15 TP must not lock.
      for (int i = 0; i < 15; i++) addVec(1, K_TP, 10'h0, 0);
      addVec(1, K_IMG, 10'h0, 0);
      for (int i = 0; i < 15; i++) addVec(1, K_TP, 10'h0, 0);
      addVec(1, K_TP, F_LOCK, 0);
      addVec(1, K_BL, F_LOCK, 0);
      // Good two-line frame.
      addVec(1, K_FS,  F_LOCK | F_VAL | F_SOF | F_SOL, 0);
      addVec(1, K_IMG, F_LOCK | F_VAL, 0);
      addVec(1, K_IMG, F_LOCK | F_VAL, 0);
      addVec(1, K_LE,  F_LOCK | F_VAL | F_EOL, 0);
      addVec(1, K_BL,  F_LOCK, 0);
      addVec(1, K_LS,  F_LOCK | F_VAL | F_SOL, 1);
      addVec(1, K_IMG, F_LOCK | F_VAL, 1);
      addVec(1, K_IMG, F_LOCK | F_VAL, 1);
      addVec(1, K_FE,  F_LOCK | F_VAL | F_EOL | F_EOF | F_FD, 1);
      // Short first line: err_len, still enters GAP, frame_done suppressed.
      addVec(1, K_FS,  F_LOCK | F_VAL | F_SOF | F_SOL, 0);
      addVec(1, K_IMG, F_LOCK | F_VAL, 0);
      addVec(1, K_LE,  F_LOCK | F_VAL | F_EOL | F_LEN, 0);
      addVec(1, K_LS,  F_LOCK | F_VAL | F_SOL, 1);
      addVec(1, K_IMG, F_LOCK | F_VAL, 1);
      addVec(1, K_IMG, F_LOCK | F_VAL, 1);
      addVec(1, K_FE,  F_LOCK | F_VAL | F_EOL | F_EOF, 1);
      // INV inside a line leaves the word count alone; FE in GAP is illegal.
      addVec(1, K_FS,  F_LOCK | F_VAL | F_SOF | F_SOL, 0);
      addVec(1, K_IMG, F_LOCK | F_VAL, 0);
      for (int i = 0; i < 3; i++) addVec(1, K_INV, F_LOCK, 0);
      addVec(1, K_IMG, F_LOCK | F_VAL, 0);
      addVec(1, K_LE,  F_LOCK | F_VAL | F_EOL, 0);
      addVec(1, K_BL,  F_LOCK, 0);
      addVec(1, K_FE,  F_LOCK | F_SEQ, 0);
      // Four INV in a line drop lock with a single realign pulse.
      addVec(1, K_FS,  F_LOCK | F_VAL | F_SOF | F_SOL, 0);
      addVec(1, K_IMG, F_LOCK | F_VAL, 0);
      for (int i = 0; i < 3; i++) addVec(1, K_INV, F_LOCK, 0);
      addVec(1, K_INV, F_REAL, 0);
      addVec(1, K_BL,  10'h0, 0);
      // Relock, then LS inside a line aborts the frame.
      for (int i = 0; i < 15; i++) addVec(1, K_TP, 10'h0, 0);
      addVec(1, K_TP,  F_LOCK, 0);
      addVec(1, K_FS,  F_LOCK | F_VAL | F_SOF | F_SOL, 0);
      addVec(1, K_IMG, F_LOCK | F_VAL, 0);
      addVec(1, K_LS,  F_LOCK | F_SEQ, 0);
      addVec(1, K_IMG, F_LOCK | F_SEQ, 0);
      addVec(1, K_FE,  F_LOCK | F_SEQ, 0);
      // enable low mid-frame: silent unlock, then TP count restarts from zero.
      addVec(1, K_FS,  F_LOCK | F_VAL | F_SOF | F_SOL, 0);
      addVec(1, K_IMG, F_LOCK | F_VAL, 0);
      addVec(0, K_IMG, 10'h0, 0);
      addVec(1, K_BL,  10'h0, 0);
      addVec(1, K_TP,  10'h0, 0);
      // Priority resolution on non-one-hot inputs (TP run continues at count 1).
      for (int i = 0; i < 14; i++) addVec(1, K_TP, 10'h0, 0);
      addVec(1, K_TP,          F_LOCK, 0);
      addVec(1, K_FS | K_IMG,  F_LOCK | F_VAL | F_SOF | F_SOL, 0);
      addVec(1, K_IMG | K_BL,  F_LOCK | F_VAL, 0);
      addVec(1, K_LE | K_INV,  F_LOCK, 0);
      addVec(1, K_FE | K_LS,   F_LOCK | F_VAL | F_EOL | F_EOF | F_LEN, 0);
      addVec(1, K_TP | K_FS,   F_LOCK, 0);
      addVec(1, K_FS,          F_LOCK | F_VAL | F_SOF | F_SOL, 0);
      addVec(1, K_LE | K_TP,   F_LOCK | F_SEQ, 0);

      @(negedge parClock);
      resetN = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].en, vecs[i].code, vecs[i].data);
         checkOutput($sformatf("vec%0d", i), {actualFlags(), lineCnt, pixData},
                     {vecs[i].flags, vecs[i].line, vecs[i].data});
      end

      // Asynchronous reset in the middle of a line clears outputs without a clock edge.
      applyStimulus(1, K_FS, 32'h1111_2222);
      checkOutput("preReset", {actualFlags(), lineCnt, pixData},
                  {F_LOCK | F_VAL | F_SOF | F_SOL, 12'd0, 32'h1111_2222});
      @(negedge parClock);
      #2;
      resetN = 1'b0;
      #1;
      checkOutput("asyncReset", {actualFlags(), lineCnt, pixData}, 54'h0);
      @(negedge parClock);
      resetN = 1'b1;
      applyStimulus(1, K_IMG, 32'h3333_4444);
      checkOutput("afterReset", {actualFlags(), lineCnt, pixData},
                  {10'h0, 12'd0, 32'h3333_4444});

`ifdef VITA_CRC_CAPTURE_EN
      for (int i = 0; i < 16; i++) applyStimulus(1, K_TP, 32'h0);
      applyStimulus(1, K_FS, 32'h0);
      applyStimulus(1, K_IMG, 32'h0);
      applyStimulus(1, K_CRC, 32'h5555_5555);
      checkOutput("crcInLine", {53'h0, crcValid}, 54'h0);
      applyStimulus(1, K_LE, 32'h0);
      applyStimulus(1, K_CRC, 32'hDEAD_BEEF);
      checkOutput("crcCapture", {21'h0, crcValid, crcWord}, {21'h0, 1'b1, 32'hDEAD_BEEF});
      applyStimulus(1, K_CRC, 32'h0BAD_0BAD);
      checkOutput("crcSecond", {21'h0, crcValid, crcWord}, {21'h0, 1'b0, 32'hDEAD_BEEF});
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/vita_frame_sequencer.md
Name: vita_frame_sequencer

Overview:
- Controller downstream of the VITA2000 LVDS synchronizer, clocked on par_clock.
- Each cycle it consumes one decoded sync code (FS/FE/LS/LE/BL/TP/IMG/CRC/INV) and one 32-bit data word (4 lanes x 8 bit).
- It sequences link lock from training patterns, then tracks frame/line structure and emits framed pixel words.
- It flags sequence and line-length errors, and requests realignment from the synchronizer/sensor control when lock is lost.

Parameters:
- TP_LOCK_COUNT, 16, consecutive TP cycles required to declare lock
- INV_LIMIT, 4, consecutive INV cycles while locked that drop lock
- WORD_W, 11, width of the per-line word counter
- LINE_W, 12, width of the per-frame line counter

Ports:
- par_clock  in  1  parallel-domain clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  run; 0 forces UNLOCKED at the next edge
- FS, FE, LS, LE, BL, TP, IMG, CRC, INV  in  1 each  one-hot-or-zero decoded sync codes
- cam_d  in  32  data word aligned with the codes
- cfg_words_per_line  in  WORD_W  expected data words per line (FS/LS word through LE/FE word inclusive)
- locked  out  1  link locked
- realign_req  out  1  one-cycle pulse on lock loss
- pix_valid  out  1  pix_data carries an image word
- pix_data  out  32  registered copy of cam_d
- pix_sof, pix_sol, pix_eol, pix_eof  out  1 each  qualifiers, valid only with pix_valid
- line_cnt  out  LINE_W  index of the current line within the frame
- frame_done  out  1  pulse one cycle after a good frame ends
- err_seq  out  1  pulse on an illegal code for the current state
- err_len  out  1  pulse when a line's word count differs from cfg_words_per_line

Behaviour:
- Reset: all outputs 0; state UNLOCKED; all counters 0.
- Every output is registered, with latency exactly 1 cycle from the input codes.
- Data framing: FS and LS cycles carry the first word of a line. IMG carries middle words. LE and FE carry the last word. BL, TP, CRC and INV carry no pixel data.
- State UNLOCKED: counts consecutive TP cycles; any other code clears the count. When the count reaches TP_LOCK_COUNT, go to IDLE and set locked=1.
- State IDLE: BL, TP and CRC are ignored.
  - FS: go to LINE with pix_sof=1, pix_sol=1, line_cnt=0, word counter=1.
  - Any other data code: err_seq pulse, stay in IDLE.
- State LINE:
  - IMG: word counter +1.
  - LE: pix_eol=1, compare the count, go to GAP.
  - FE: pix_eol=1, pix_eof=1, compare the count, go to IDLE, frame_done pulse if the frame had no error.
  - BL, TP, FS, LS: err_seq pulse, discard the frame, go to IDLE.
- State GAP: BL and CRC are ignored.
  - LS: line_cnt +1, pix_sol=1, go to LINE.
  - FS, IMG, LE, FE: err_seq pulse, go to IDLE.
- Length compare: in the cycle that presents LE/FE, the counter value +1 must equal cfg_words_per_line, else err_len pulse. The word counter saturates at its maximum and does not wrap.
- line_cnt saturates at 2^LINE_W-1.
- INV while locked: increments an INV run counter; any non-INV code clears it. Reaching INV_LIMIT gives locked=0, a realign_req pulse and a return to UNLOCKED.
- An INV cycle inside LINE does not change the word counter.
- Simultaneous events: if the inputs violate one-hot, the priority is INV > TP > FS > FE > LS > LE > IMG > CRC > BL.
- enable deasserted mid-frame: the next edge forces UNLOCKED. No eof/eol is emitted and no realign_req.
- reset_n asserted mid-frame: immediate return to reset values.

Optional Feature:
- Macro: VITA_CRC_CAPTURE_EN.
- When defined, adds two outputs:
  - crc_word [31:0]: registers cam_d on the first CRC cycle after LE/FE.
  - crc_valid: pulses with it, 1-cycle latency.
- When undefined, neither port exists and CRC cycles are simply ignored.

Decomposition:
- Package vita_sync_pkg holds:
  - the state enum (UNLOCKED, IDLE, LINE, GAP);
  - the sync word constants (FS 8'hAA, FE 8'hCA, LS 8'h2A, LE 8'h4A, BL 8'h05, IMG 8'h0D, CRC 8'h16, TP 8'hE9);
  - the default widths.
- Sub-module vita_lock_monitor holds the TP lock counter and the INV loss counter. It outputs locked and realign_req.

Test Plan:
- 16 TP cycles then BL -> locked rises on the cycle after the 16th TP. 15 TP, IMG, 16 TP -> lock only after the second run.
- Locked, cfg=4: FS, IMG, IMG, LE, BL, LS, IMG, IMG, FE ->
  - 8 pix_valid words;
  - sof on word 0, eol on words 3 and 7, eof on word 7;
  - line_cnt 0 then 1;
  - frame_done pulse; no errors.
- cfg=4: FS, IMG, LE -> err_len pulse with pix_eol; state GAP.
- Locked in LINE: 4 consecutive INV -> realign_req one pulse, locked=0; 3 INV then IMG -> still locked, counter unchanged.
- In LINE: LS arrives -> err_seq pulse, state IDLE, no frame_done at the following FE.
- With VITA_CRC_CAPTURE_EN: LE then CRC with cam_d=32'hDEADBEEF -> crc_valid pulse, crc_word=32'hDEADBEEF.
